rr_arb2: RTL and testbench
==========================

# rr_arb2

Two-requester round-robin arbiter with valid/ready handshakes and a registered output stage. It drives the `s` select of a `W`-wide bank of `mux21` instances, which steer `d0_data`/`d1_data` into the output register. It sits directly upstream of, and wraps, the 2:1 mux datapath.

## Interface
- `W`, 8: data width per channel, ≥1.
- `MAX_BURST`, 4: max consecutive transfers per grant, ≥2.

- `clk` in 1: sole clock, all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `d0_valid` in 1: channel 0 has data.
- `d0_data` in W: channel 0 payload.
- `d0_ready` out 1: channel 0 word accepted this cycle.
- `d1_valid` in 1: channel 1 has data.
- `d1_data` in W: channel 1 payload.
- `d1_ready` out 1: channel 1 word accepted this cycle.
- `y_valid` out 1: output register holds a word.
- `y_data` out W: output payload.
- `y_ready` in 1: consumer accepts output this cycle.
- `s` out 1: current/last grant; 0 = channel 0, 1 = channel 1. Registered, drives `mux21` selects.

## Operation
- States: IDLE (arbitrating, no transfers) and BURST (grant locked to `s`).
- Register `s` doubles as round-robin pointer; in IDLE it holds the last grant.
- `accept = !y_valid || y_ready`.
- IDLE, at the clock edge:
  - Only d0_valid: s←0, go BURST.
  - Only d1_valid: s←1, go BURST.
  - Both: s←!s, go BURST.
  - Neither: stay IDLE, s unchanged.
- BURST:
  - `dX_ready = (s==X) && accept`; the non-granted ready is always 0.
  - A transfer is granted valid && accept: y_data←mux output, y_valid←1, cnt←cnt+1.
  - Transfer with cnt==MAX_BURST-1: cnt←0, go IDLE.
  - Granted valid low: no transfer, cnt←0, go IDLE. The other channel's valid is ignored until IDLE.
- Output register: if y_valid && y_ready with no new transfer, y_valid←0. A simultaneous drain and fill keeps y_valid=1 with new data, giving full throughput.
- Both readies are 0 in IDLE.
- `cnt` width is $clog2(MAX_BURST), range 0..MAX_BURST-1, and never wraps past MAX_BURST-1.
- Reset values: state IDLE, s=1 (so channel 0 wins the first tie), cnt=0, y_valid=0, y_data=0. d0_ready and d1_ready are 0 during reset.
- Reset asserted mid-burst: the in-flight output word is discarded and no ready is asserted in that cycle.

## Timing
- Request-to-grant: valid sampled in IDLE at cycle N → s updated and BURST entered at cycle N+1.
- Grant-to-output: transfer at cycle N+1 → y_valid=1 at cycle N+2.
- Minimum latency is 2 cycles from d*_valid to y_valid.
- Sustained rate: 1 word/cycle within a burst, plus 1 idle arbitration cycle between bursts.
- Backpressure: y_ready low with y_valid=1 forces both readies to 0 in the same cycle (combinational from y_ready). y_data stays stable while y_valid && !y_ready.
- Producers must hold valid/data stable until their ready is seen; the arbiter does not require it for correctness.

## Structure
- Package `rr_arb2_pkg` holds:
  - `typedef enum logic {IDLE, BURST} arb_state_t`
  - a `cnt_w` helper function (`$clog2`).
- Datapath: generate loop of `W` instances of `mux21` (`s`→`s`, `d0_data[i]`→`d0`, `d1_data[i]`→`d1`, output→register input).
- No other sub-modules. FSM, counter and output register are in `rr_arb2`.

## Test plan
- Single requester: d0_valid=1 with data 0x11,0x22,0x33,0x44,0x55, y_ready=1.
  - Expect s=0.
  - y_data sequence 0x11..0x44, then one IDLE cycle, then 0x55.
  - y_valid first high 2 cycles after d0_valid.
- Tie after reset: both valid continuously, d0=0xA0.., d1=0xB0.., y_ready=1.
  - Expect 4×A, gap, 4×B, gap, 4×A.
  - s toggles 0→1→0.
- Backpressure: y_ready=0 for 3 cycles mid-burst.
  - y_data and y_valid held.
  - d0_ready=0 in those cycles.
  - No word lost or duplicated; cnt does not advance.
- Early release: d1 valid for 2 words then low, with d0 valid throughout.
  - Expect burst ends after 2 transfers, IDLE, then grant to s=0.
- Reset mid-burst: rst_n low for 1 cycle after 2 transfers.
  - Next cycle y_valid=0, s=1, both readies 0.
  - d0 wins the next tie.
- Full-throughput drain/fill: y_ready=1, d1 streaming 0x01..0x04.
  - y_valid stays high for 4 consecutive cycles with no bubble.

Source files
------------

// File: rtl/rr_arb2_pkg.sv
// Shared types and helpers for the two-requester round-robin arbiter.
package rr_arb2_pkg;

    typedef enum logic {IDLE, BURST} arb_state_t;

    // Burst counter width; never narrower than one bit.
    function automatic int cnt_w(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/rr_arb2_mux21.sv
// Single-bit 2:1 multiplexer; s=0 passes d0, s=1 passes d1.
module mux21 (
    input  logic s,
    input  logic d0,
    input  logic d1,
    output logic y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with bounded bursts, valid/ready handshakes
// and a registered output stage fed through a bank of mux21 cells.
module rr_arb2
    import rr_arb2_pkg::*;
#(
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         d0_valid,
    input  logic [W-1:0] d0_data,
    output logic         d0_ready,
    input  logic         d1_valid,
    input  logic [W-1:0] d1_data,
    output logic         d1_ready,
    output logic         y_valid,
    output logic [W-1:0] y_data,
    input  logic         y_ready,
    output logic         s
);

    localparam int             CW       = cnt_w(MAX_BURST);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    arb_state_t    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  mux_y;
    logic          accept;
    logic          granted_valid;
    logic          xfer;

    assign accept        = !y_valid || y_ready;
    assign granted_valid = s ? d1_valid : d0_valid;
    assign xfer          = (state == BURST) && granted_valid && accept;

    // Readies are masked by reset so nothing is handed off while it is held.
    assign d0_ready = rst_n && (state == BURST) && !s && accept;
    assign d1_ready = rst_n && (state == BURST) &&  s && accept;

    for (genvar i = 0; i < W; i++) begin : g_mux
        mux21 u_mux (
            .s  (s),
            .d0 (d0_data[i]),
            .d1 (d1_data[i]),
            .y  (mux_y[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            s       <= 1'b1;
            cnt     <= '0;
            y_valid <= 1'b0;
            y_data  <= '0;
        end else begin
            if (xfer) begin
                y_data  <= mux_y;
                y_valid <= 1'b1;
            end else if (y_ready) begin
                y_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // s is the round-robin pointer: on a tie the other channel wins.
                    if (d0_valid && d1_valid) begin
                        s     <= !s;
                        state <= BURST;
                    end else if (d0_valid) begin
                        s     <= 1'b0;
                        state <= BURST;
                    end else if (d1_valid) begin
                        s     <= 1'b1;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (!granted_valid) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (accept) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb2.sv
// Directed, table-driven bench for rr_arb2 with hand-computed per-cycle expectations.
module tb_rr_arb2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       d0_valid, d1_valid, y_ready;
    logic [7:0] d0_data, d1_data;
    logic       d0_ready, d1_ready, y_valid, s;
    logic [7:0] y_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst_n;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       yr;
        logic       r0;
        logic       r1;
        logic       yv;
        logic [7:0] yd;
        logic       s;
    } vec_t;

    vec_t tbl[$];

    rr_arb2 #(.W(8), .MAX_BURST(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d0_valid (d0_valid),
        .d0_data  (d0_data),
        .d0_ready (d0_ready),
        .d1_valid (d1_valid),
        .d1_data  (d1_data),
        .d1_ready (d1_ready),
        .y_valid  (y_valid),
        .y_data   (y_data),
        .y_ready  (y_ready),
        .s        (s)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic rn, input logic v0, input logic [7:0] d0,
                                input logic v1, input logic [7:0] d1, input logic yr,
                                input logic r0, input logic r1, input logic yv,
                                input logic [7:0] yd, input logic es);
        vec_t v;
        v.rst_n = rn; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.yr = yr;
        v.r0 = r0; v.r1 = r1; v.yv = yv; v.yd = yd; v.s = es;
        return v;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic apply_stimulus(input logic rn, input logic v0, input logic [7:0] d0,
                                  input logic v1, input logic [7:0] d1, input logic yr);
        @(negedge clk);
        rst_n = rn; d0_valid = v0; d0_data = d0; d1_valid = v1; d1_data = d1; y_ready = yr;
        #1;
    endtask

    task automatic check_output(input string name, input logic r0, input logic r1,
                                input logic yv, input logic [7:0] yd, input logic es);
        n_checks++;
        if ({d0_ready, d1_ready, y_valid, y_data, s} !== {r0, r1, yv, yd, es}) begin
            n_fail++;
            $display("[TB] FAIL %s: got r0=%b r1=%b yv=%b yd=%h s=%b, want r0=%b r1=%b yv=%b yd=%h s=%b",
                     name, d0_ready, d1_ready, y_valid, y_data, s, r0, r1, yv, yd, es);
        end
    endtask

    task automatic step(input string name, input logic rn, input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1, input logic yr,
                        input logic r0, input logic r1, input logic yv,
                        input logic [7:0] yd, input logic es);
        apply_stimulus(rn, v0, d0, v1, d1, yr);
        check_output(name, r0, r1, yv, yd, es);
    endtask

    initial begin
        rst_n = 1'b0; d0_valid = 1'b0; d1_valid = 1'b0;
        d0_data = '0; d1_data = '0; y_ready = 1'b1;

        // Single requester on channel 0: four words, arbitration gap, fifth word.
        tbl.push_back(mk(1, 1, 8'h11, 0, 8'h00, 1,  0, 0, 0, 8'h00, 1));
        tbl.push_back(mk(1, 1, 8'h11, 0, 8'h00, 1,  1, 0, 0, 8'h00, 0));
        tbl.push_back(mk(1, 1, 8'h22, 0, 8'h00, 1,  1, 0, 1, 8'h11, 0));
        tbl.push_back(mk(1, 1, 8'h33, 0, 8'h00, 1,  1, 0, 1, 8'h22, 0));
        tbl.push_back(mk(1, 1, 8'h44, 0, 8'h00, 1,  1, 0, 1, 8'h33, 0));
        tbl.push_back(mk(1, 1, 8'h55, 0, 8'h00, 1,  0, 0, 1, 8'h44, 0));
        tbl.push_back(mk(1, 1, 8'h55, 0, 8'h00, 1,  1, 0, 0, 8'h44, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 1,  1, 0, 1, 8'h55, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h55, 0));
        // Reset, then both channels requesting continuously.
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h55, 0));
        tbl.push_back(mk(1, 1, 8'hA0, 1, 8'hB0, 1,  0, 0, 0, 8'h00, 1));
        tbl.push_back(mk(1, 1, 8'hA0, 1, 8'hB0, 1,  1, 0, 0, 8'h00, 0));
        tbl.push_back(mk(1, 1, 8'hA1, 1, 8'hB0, 1,  1, 0, 1, 8'hA0, 0));
        tbl.push_back(mk(1, 1, 8'hA2, 1, 8'hB0, 1,  1, 0, 1, 8'hA1, 0));
        tbl.push_back(mk(1, 1, 8'hA3, 1, 8'hB0, 1,  1, 0, 1, 8'hA2, 0));
        tbl.push_back(mk(1, 1, 8'hA4, 1, 8'hB0, 1,  0, 0, 1, 8'hA3, 0));
        tbl.push_back(mk(1, 1, 8'hA4, 1, 8'hB0, 1,  0, 1, 0, 8'hA3, 1));
        tbl.push_back(mk(1, 1, 8'hA4, 1, 8'hB1, 1,  0, 1, 1, 8'hB0, 1));
        tbl.push_back(mk(1, 1, 8'hA4, 1, 8'hB2, 1,  0, 1, 1, 8'hB1, 1));
        tbl.push_back(mk(1, 1, 8'hA4, 1, 8'hB3, 1,  0, 1, 1, 8'hB2, 1));
        tbl.push_back(mk(1, 1, 8'hA4, 1, 8'hB4, 1,  0, 0, 1, 8'hB3, 1));
        tbl.push_back(mk(1, 1, 8'hA4, 1, 8'hB4, 1,  1, 0, 0, 8'hB3, 0));
        tbl.push_back(mk(1, 1, 8'hA5, 1, 8'hB4, 1,  1, 0, 1, 8'hA4, 0));
        tbl.push_back(mk(1, 1, 8'hA6, 1, 8'hB4, 1,  1, 0, 1, 8'hA5, 0));
        tbl.push_back(mk(1, 1, 8'hA7, 1, 8'hB4, 1,  1, 0, 1, 8'hA6, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'hA7, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'hA7, 0));

        // Reset with both valids high: readies must stay low.
        apply_stimulus(0, 1, 8'h00, 1, 8'h00, 1);
        step("reset", 0, 1, 8'h00, 1, 8'h00, 1,  0, 0, 0, 8'h00, 1);

        foreach (tbl[i]) begin
            apply_stimulus(tbl[i].rst_n, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].yr);
            check_output($sformatf("vec%0d", i), tbl[i].r0, tbl[i].r1, tbl[i].yv, tbl[i].yd, tbl[i].s);
        end

        // Backpressure mid-burst: output held, ready low, counter frozen.
        step("bp0", 1, 1, 8'hC1, 0, 8'h00, 1,  0, 0, 0, 8'hA7, 0);
        step("bp1", 1, 1, 8'hC1, 0, 8'h00, 1,  1, 0, 0, 8'hA7, 0);
        step("bp2", 1, 1, 8'hC2, 0, 8'h00, 1,  1, 0, 1, 8'hC1, 0);
        step("bp3", 1, 1, 8'hC3, 0, 8'h00, 0,  0, 0, 1, 8'hC2, 0);
        step("bp4", 1, 1, 8'hC3, 0, 8'h00, 0,  0, 0, 1, 8'hC2, 0);
        step("bp5", 1, 1, 8'hC3, 0, 8'h00, 0,  0, 0, 1, 8'hC2, 0);
        step("bp6", 1, 1, 8'hC3, 0, 8'h00, 1,  1, 0, 1, 8'hC2, 0);
        step("bp7", 1, 1, 8'hC4, 0, 8'h00, 1,  1, 0, 1, 8'hC3, 0);
        step("bp8", 1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'hC4, 0);
        step("bp9", 1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'hC4, 0);

        // Early release by channel 1 after two words; channel 0 then granted.
        step("er0", 1, 1, 8'hD0, 1, 8'hE0, 1,  0, 0, 0, 8'hC4, 0);
        step("er1", 1, 1, 8'hD0, 1, 8'hE0, 1,  0, 1, 0, 8'hC4, 1);
        step("er2", 1, 1, 8'hD0, 1, 8'hE1, 1,  0, 1, 1, 8'hE0, 1);
        step("er3", 1, 1, 8'hD0, 0, 8'h00, 1,  0, 1, 1, 8'hE1, 1);
        step("er4", 1, 1, 8'hD0, 0, 8'h00, 1,  0, 0, 0, 8'hE1, 1);
        step("er5", 1, 1, 8'hD0, 0, 8'h00, 1,  1, 0, 0, 8'hE1, 0);
        step("er6", 1, 1, 8'hD1, 0, 8'h00, 1,  1, 0, 1, 8'hD0, 0);
        step("er7", 1, 0, 8'h00, 0, 8'h00, 1,  1, 0, 1, 8'hD1, 0);
        step("er8", 1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'hD1, 0);

        // Reset after two transfers of a channel-1 burst.
        step("rm0", 1, 0, 8'h00, 1, 8'hF0, 1,  0, 0, 0, 8'hD1, 0);
        step("rm1", 1, 0, 8'h00, 1, 8'hF0, 1,  0, 1, 0, 8'hD1, 1);
        step("rm2", 1, 0, 8'h00, 1, 8'hF1, 1,  0, 1, 1, 8'hF0, 1);
        step("rm3", 0, 0, 8'h00, 1, 8'hF2, 1,  0, 0, 1, 8'hF1, 1);
        step("rm4", 1, 1, 8'h90, 1, 8'hF2, 1,  0, 0, 0, 8'h00, 1);
        step("rm5", 1, 1, 8'h90, 1, 8'hF2, 1,  1, 0, 0, 8'h00, 0);
        step("rm6", 1, 1, 8'h91, 1, 8'hF2, 1,  1, 0, 1, 8'h90, 0);
        step("rm7", 1, 0, 8'h00, 0, 8'h00, 1,  1, 0, 1, 8'h91, 0);
        step("rm8", 1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h91, 0);

        // Full-throughput drain and fill from channel 1.
        step("ff0", 1, 0, 8'h00, 1, 8'h01, 1,  0, 0, 0, 8'h91, 0);
        step("ff1", 1, 0, 8'h00, 1, 8'h01, 1,  0, 1, 0, 8'h91, 1);
        step("ff2", 1, 0, 8'h00, 1, 8'h02, 1,  0, 1, 1, 8'h01, 1);
        step("ff3", 1, 0, 8'h00, 1, 8'h03, 1,  0, 1, 1, 8'h02, 1);
        step("ff4", 1, 0, 8'h00, 1, 8'h04, 1,  0, 1, 1, 8'h03, 1);
        step("ff5", 1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'h04, 1);
        step("ff6", 1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h04, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
